// File: rtl/vga_tile_pkg.sv
// Shared VGA timing constants and tile-code type for the 2048 board display.
package vga_tile_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int BOARD_N = 4;

  typedef logic [3:0] tile_code_t;

  localparam tile_code_t TILE_EMPTY = 4'd0;
  localparam tile_code_t TILE_2048  = 4'd11;

endpackage

// File: rtl/tile_axis_tracker.sv
// Incremental per-axis grid locator: tracks tile index and offset-in-pitch
// from a restart point instead of dividing the raster coordinate.
module tile_axis_tracker #(
  parameter int ORIGIN = 0,
  parameter int TILE   = 96,
  parameter int GAP    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_restart,
  input  logic       i_advance,
  output logic [1:0] o_idx,
  output logic       o_in
);

  localparam int PITCH = GAP + TILE;
  localparam int OFF_W = $clog2(PITCH);
  localparam logic [OFF_W-1:0] OFF_LAST  = OFF_W'(PITCH - 1);
  localparam logic [OFF_W-1:0] GAP_C     = OFF_W'(GAP);
  localparam logic             RST_VALID = (ORIGIN == 0);

  logic [OFF_W-1:0] r_off;
  logic [1:0]       r_idx;
  logic             r_valid;

  // Once past the fourth tile the tracker parks at idx 3 until the next restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_off   <= '0;
      r_idx   <= '0;
      r_valid <= RST_VALID;
    end else if (i_restart) begin
      r_off   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b1;
    end else if (i_advance && r_valid) begin
      if (r_off == OFF_LAST) begin
        r_off <= '0;
        if (r_idx == 2'd3) r_valid <= 1'b0;
        else               r_idx   <= r_idx + 2'd1;
      end else begin
        r_off <= r_off + OFF_W'(1);
      end
    end
  end

  assign o_idx = r_idx;
  assign o_in  = r_valid && (r_off >= GAP_C);

endmodule

// File: rtl/vga_tile_scanner.sv
// 640x480@60 raster scanner: locates each pixel in the 4x4 tile grid and
// emits the board tile code with sync, two pix_ce ticks behind the counters.
module vga_tile_scanner
  import vga_tile_pkg::*;
#(
  parameter int TILE = 96,
  parameter int GAP  = 12,
  parameter int X0   = 104,
  parameter int Y0   = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [1:0] wr_col,
  input  logic [3:0] wr_code,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [3:0] state,
  output logic       inpos,
  output logic       frame_start
);

  localparam logic [9:0] HC_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] VC_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] X0_C     = 10'(X0);
  localparam logic [9:0] Y0_C     = 10'(Y0);

  logic [9:0] r_hc, r_vc;
  logic [9:0] w_hc_next, w_vc_next;
  logic       w_hc_last, w_vc_last;
  logic [1:0] w_col, w_row;
  logic       w_xin, w_yin;

  tile_code_t r_board [BOARD_N*BOARD_N];

  // S0: raster counters
  assign w_hc_last = (r_hc == HC_LAST);
  assign w_vc_last = (r_vc == VC_LAST);
  assign w_hc_next = w_hc_last ? '0 : r_hc + 10'd1;
  assign w_vc_next = w_hc_last ? (w_vc_last ? '0 : r_vc + 10'd1) : r_vc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (pix_ce) begin
      r_hc <= w_hc_next;
      r_vc <= w_vc_next;
    end
  end

  // Trackers restart on the tick that moves the counter onto the origin, so
  // their state always describes the current counter value.
  tile_axis_tracker #(.ORIGIN(X0), .TILE(TILE), .GAP(GAP)) u_x_trk (
    .clk       (clk),
    .rst       (rst),
    .i_restart (pix_ce && (w_hc_next == X0_C)),
    .i_advance (pix_ce),
    .o_idx     (w_col),
    .o_in      (w_xin)
  );

  tile_axis_tracker #(.ORIGIN(Y0), .TILE(TILE), .GAP(GAP)) u_y_trk (
    .clk       (clk),
    .rst       (rst),
    .i_restart (pix_ce && w_hc_last && (w_vc_next == Y0_C)),
    .i_advance (pix_ce && w_hc_last),
    .o_idx     (w_row),
    .o_in      (w_yin)
  );

  // S1: registered sync, active area, axis flags and cell index
  logic       r_hs_p1, r_vs_p1, r_von_p1, r_xin_p1, r_yin_p1, r_fs_p1;
  logic [1:0] r_col_p1, r_row_p1;
  logic       w_inpos_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs_p1  <= 1'b1;
      r_vs_p1  <= 1'b1;
      r_von_p1 <= 1'b0;
      r_xin_p1 <= 1'b0;
      r_yin_p1 <= 1'b0;
      r_fs_p1  <= 1'b0;
      r_col_p1 <= '0;
      r_row_p1 <= '0;
    end else if (pix_ce) begin
      r_hs_p1  <= !((r_hc >= HS_START) && (r_hc <= HS_END));
      r_vs_p1  <= !((r_vc >= VS_START) && (r_vc <= VS_END));
      r_von_p1 <= (r_hc < H_ACT) && (r_vc < V_ACT);
      r_xin_p1 <= w_xin;
      r_yin_p1 <= w_yin;
      r_fs_p1  <= (r_hc == '0) && (r_vc == '0);
      r_col_p1 <= w_col;
      r_row_p1 <= w_row;
    end
  end

  assign w_inpos_p1 = r_xin_p1 && r_yin_p1 && r_von_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BOARD_N*BOARD_N; i++) r_board[i] <= TILE_EMPTY;
    end else if (wr_en) begin
      r_board[{wr_row, wr_col}] <= wr_code;
    end
  end

  // S2: board read and output registers; frame_start lasts one clk only
  logic       r_hs_p2, r_vs_p2, r_von_p2, r_inpos_p2, r_fs_p2;
  tile_code_t r_state_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs_p2    <= 1'b1;
      r_vs_p2    <= 1'b1;
      r_von_p2   <= 1'b0;
      r_inpos_p2 <= 1'b0;
      r_state_p2 <= TILE_EMPTY;
      r_fs_p2    <= 1'b0;
    end else begin
      r_fs_p2 <= pix_ce && r_fs_p1;
      if (pix_ce) begin
        r_hs_p2    <= r_hs_p1;
        r_vs_p2    <= r_vs_p1;
        r_von_p2   <= r_von_p1;
        r_inpos_p2 <= w_inpos_p1;
        r_state_p2 <= w_inpos_p1 ? r_board[{r_row_p1, r_col_p1}] : TILE_EMPTY;
      end
    end
  end

  assign hsync       = r_hs_p2;
  assign vsync       = r_vs_p2;
  assign video_on    = r_von_p2;
  assign inpos       = r_inpos_p2;
  assign state       = r_state_p2;
  assign frame_start = r_fs_p2;

endmodule
